pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 98 +++++++++
 tb/tb_pipe_stage_reg.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush and NOP bubbles.
// Define PIPE_SKID_EN for a two-entry output+skid stage with a registered in_ready_o.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              accept;
  logic              drain;
  logic              out_vld_q;
  logic [CTRL_W-1:0] out_ctrl_q;
  logic [DATA_W-1:0] out_data_q;

  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_vld_q && out_ready_i;
  assign out_valid_o = out_vld_q;
  // Bubbles must look like NOPs downstream, whatever the stale register holds.
  assign out_ctrl_o  = out_vld_q ? out_ctrl_q : '0;
  assign out_data_o  = out_data_q;

`ifdef PIPE_SKID_EN
  logic              skid_vld_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  // Ready depends only on the skid flop, so out_ready_i never reaches in_ready_o.
  assign in_ready_o = !skid_vld_q;
  assign count_o    = {out_vld_q & skid_vld_q, out_vld_q ^ skid_vld_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q   <= 1'b0;
      out_ctrl_q  <= '0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else if (flush_i) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (drain) begin
      if (skid_vld_q) begin
        out_ctrl_q <= skid_ctrl_q;
        out_data_q <= skid_data_q;
        skid_vld_q <= 1'b0;
      end else if (accept) begin
        out_ctrl_q <= in_ctrl_i;
        out_data_q <= in_data_i;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q) begin
        out_vld_q  <= 1'b1;
        out_ctrl_q <= in_ctrl_i;
        out_data_q <= in_data_i;
      end else begin
        skid_vld_q  <= 1'b1;
        skid_ctrl_q <= in_ctrl_i;
        skid_data_q <= in_data_i;
      end
    end
  end
`else
  assign in_ready_o = !out_vld_q || out_ready_i;
  assign count_o    = {1'b0, out_vld_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_ctrl_q <= '0;
      out_data_q <= '0;
    end else if (flush_i) begin
      out_vld_q <= 1'b0;
    end else if (accept) begin
      out_vld_q  <= 1'b1;
      out_ctrl_q <= in_ctrl_i;
      out_data_q <= in_data_i;
    end else if (drain) begin
      out_vld_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios plus random traffic
// against a capacity-limited FIFO model of the stage.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [CW-1:0] in_ctrl_i, out_ctrl_o;
  logic [DW-1:0] in_data_i, out_data_o;
  logic [1:0]    count_o;

  logic [CW+DW-1:0] q[$];
  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_ctrl_i(in_ctrl_i), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_ctrl_o(out_ctrl_o), .out_data_o(out_data_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the accepted entry enters the model at the clock edge.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic r);
    logic acc, clr;
    in_valid_i = v; in_ctrl_i = c; in_data_i = d;
    out_ready_i = ordy; flush_i = fl; rst = r;
    @(negedge clk);
    acc = v && in_ready_o && !fl && !r;
    clr = fl || r;
    @(posedge clk);
    if (clr) q.delete();
    else if (acc) q.push_back({c, d});
    #1;
  endtask

  // Monitor: compares DUT state against the model each cycle, pops on drain.
  initial begin
    logic          prev_ok = 1'b0;
    logic          after_rst = 1'b0;
    logic          prev_v = 1'b0, prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          exp_rdy;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ok = 1'b0;
        after_rst = 1'b1;
        continue;
      end
      if (after_rst) chk("reset_data", out_data_o, 0);
      after_rst = 1'b0;
      chk("count", count_o, q.size());
      chk("out_valid", out_valid_o, q.size() != 0);
      exp_rdy = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready_i);
      chk("in_ready", in_ready_o, exp_rdy);
      if (q.size() != 0) begin
        chk("out_ctrl", out_ctrl_o, q[0][CW+DW-1:DW]);
        chk("out_data", out_data_o, q[0][DW-1:0]);
      end else begin
        chk("bubble_ctrl", out_ctrl_o, 0);
      end
      if (prev_ok && (!out_valid_o || (prev_v && !prev_r)))
        chk("data_hold", out_data_o, prev_d);
      if (out_valid_o && out_ready_i && q.size() != 0) void'(q.pop_front());
      prev_ok = 1'b1; prev_v = out_valid_o; prev_r = out_ready_i; prev_d = out_data_o;
    end
  end

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // streaming, then bubbles
    for (int i = 0; i < 4; i++) step(1, 8'h5A, 32'h1000 + i, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 32'h0, 1, 0, 0);
    // backpressure A,B,C then release
    step(1, 8'hA1, 32'hAAAA_0001, 0, 0, 0);
    step(1, 8'hB2, 32'hBBBB_0002, 0, 0, 0);
    step(1, 8'hC3, 32'hCCCC_0003, 0, 0, 0);
    step(1, 8'hC3, 32'hCCCC_0003, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    // flush with same-cycle offer
    step(1, 8'h11, 32'h1111, 0, 0, 0);
    step(1, 8'h22, 32'h2222, 0, 0, 0);
    step(1, 8'h33, 32'hDEAD, 0, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);
    // reset mid-operation with flush and offer
    step(1, 8'h44, 32'h4444, 0, 0, 0);
    step(1, 8'h55, 32'h5555, 0, 0, 0);
    step(1, 8'h66, 32'hBEEF, 0, 1, 1);
    step(0, 0, 0, 1, 0, 0);
    // full stage: ready low blocks, ready high replaces drained entry
    step(1, 8'h77, 32'h7777, 0, 0, 0);
    step(1, 8'h88, 32'h8888, 0, 0, 0);
    step(1, 8'h99, 32'h9999, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, CW'($urandom), $urandom, $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
    chk("final_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
